// File: rtl/ecsu_dwell_fsm.sv
// Emergency control state unit with escalate-now / dwell-to-de-escalate rules.
// Optional emergency-entry counter enabled by ECSU_EMERG_COUNT_EN.
module ecsu_dwell_fsm #(
  parameter int WIND_W       = 6,
  parameter int TEMP_W       = 8,
  parameter int CAUTION_WIND = 10,
  parameter int HIGH_WIND    = 15,
  parameter int EMERG_WIND   = 20,
  parameter int TEMP_HIGH    = 35,
  parameter int TEMP_EMERG   = 40,
  parameter int DWELL        = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     thunderstorm,
  input  logic [WIND_W-1:0]        wind,
  input  logic [1:0]               visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  input  logic                     ack,
  output logic                     severe_weather,
  output logic                     emergency_landing_alert,
  output logic [1:0]               ECSU_state,
  output logic                     state_changed,
  output logic [7:0]               emerg_count
);

  localparam logic [1:0] ALL_CLEAR  = 2'b00;
  localparam logic [1:0] CAUTION    = 2'b01;
  localparam logic [1:0] HIGH_ALERT = 2'b10;
  localparam logic [1:0] EMERGENCY  = 2'b11;

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DW_MAX = CW'(DWELL - 1);

  localparam logic [WIND_W-1:0] W_CAU = WIND_W'(CAUTION_WIND);
  localparam logic [WIND_W-1:0] W_HI  = WIND_W'(HIGH_WIND);
  localparam logic [WIND_W-1:0] W_EM  = WIND_W'(EMERG_WIND);

  localparam logic signed [TEMP_W-1:0] T_HI_P = TEMP_W'(TEMP_HIGH);
  localparam logic signed [TEMP_W-1:0] T_HI_N = TEMP_W'(-TEMP_HIGH);
  localparam logic signed [TEMP_W-1:0] T_EM_P = TEMP_W'(TEMP_EMERG);
  localparam logic signed [TEMP_W-1:0] T_EM_N = TEMP_W'(-TEMP_EMERG);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0]    level;
  logic          sev_q, alrt_q, chg_q;

  // Severity level of the current inputs, highest matching class first.
  always_comb begin
    level = ALL_CLEAR;
    if (wind > W_EM || temperature > T_EM_P ||
        temperature < T_EM_N)
      level = EMERGENCY;
    else if (wind > W_HI || visibility == 2'b11 ||
             temperature > T_HI_P ||
             temperature < T_HI_N || thunderstorm)
      level = HIGH_ALERT;
    else if (wind > W_CAU || visibility == 2'b01 ||
             visibility == 2'b10)
      level = CAUTION;
  end

  // Next state: escalate at once, step down only after DWELL quiet cycles.
  always_comb begin
    state_d = state_q;
    dwell_d = '0;
    if (level > state_q) begin
      state_d = level;
    end else if (state_q == EMERGENCY) begin
      if (ack && level != EMERGENCY)
        state_d = HIGH_ALERT;
    end else if (level < state_q) begin
      if (dwell_q == DW_MAX)
        state_d = state_q - 2'd1;
      else
        dwell_d = dwell_q + 1'b1;
    end
  end

  // State, dwell counter and registered decoded outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ALL_CLEAR;
      dwell_q <= '0;
      sev_q   <= 1'b0;
      alrt_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      sev_q   <= state_d[1];
      alrt_q  <= (state_d == EMERGENCY);
      chg_q   <= (state_d != state_q);
    end
  end

  assign ECSU_state              = state_q;
  assign severe_weather          = sev_q;
  assign emergency_landing_alert = alrt_q;
  assign state_changed           = chg_q;

`ifdef ECSU_EMERG_COUNT_EN
  logic [7:0] ecnt_q;
  logic       enter;

  assign enter = (state_d == EMERGENCY) &&
                 (state_q != EMERGENCY);

  // Saturating count of entries into EMERGENCY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ecnt_q <= 8'd0;
    else if (enter && ecnt_q != 8'hFF)
      ecnt_q <= ecnt_q + 8'd1;
  end

  assign emerg_count = ecnt_q;
`else
  assign emerg_count = 8'd0;
`endif

endmodule

// File: tb/tb_ecsu_dwell_fsm.sv
// Directed + random bench for ecsu_dwell_fsm against a
// rule-level reference model.
module tb_ecsu_dwell_fsm;

  localparam int DW = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              ts = 1'b0;
  logic [5:0]        wind = '0;
  logic [1:0]        vis = '0;
  logic signed [7:0] temp = '0;
  logic              ack = 1'b0;
  logic              sev, alrt, chg;
  logic [1:0]        st;
  logic [7:0]        ecnt;

  int checks = 0;
  int errors = 0;

  int m_st = 0;
  int m_dc = 0;
  int m_chg = 0;
  int m_ec = 0;

  ecsu_dwell_fsm dut (
    .CLK(CLK),
    .RST(RST),
    .thunderstorm(ts),
    .wind(wind),
    .visibility(vis),
    .temperature(temp),
    .ack(ack),
    .severe_weather(sev),
    .emergency_landing_alert(alrt),
    .ECSU_state(st),
    .state_changed(chg),
    .emerg_count(ecnt)
  );

  always #5 CLK = ~CLK;

  function automatic int lvl();
    int w, t;
    w = int'(wind);
    t = int'(temp);
    if (w > 20 || t > 40 || t < -40) return 3;
    if (w > 15 || vis == 2'd3 || t > 35 || t < -35 || ts)
      return 2;
    if (w > 10 || vis == 2'd1 || vis == 2'd2) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    int l, prev;
    l = lvl();
    prev = m_st;
    if (l > m_st) begin
      m_st = l;
      m_dc = 0;
    end else if (m_st == 3) begin
      if (ack && l < 3) m_st = 2;
      m_dc = 0;
    end else if (l < m_st) begin
      m_dc = m_dc + 1;
      if (m_dc == DW) begin
        m_st = m_st - 1;
        m_dc = 0;
      end
    end else begin
      m_dc = 0;
    end
    m_chg = (m_st != prev) ? 1 : 0;
    if (m_st == 3 && prev != 3 && m_ec < 255)
      m_ec = m_ec + 1;
  endtask

  task automatic model_reset();
    m_st = 0;
    m_dc = 0;
    m_chg = 0;
    m_ec = 0;
  endtask

  task automatic chk(input string tag);
    int exp_ec;
`ifdef ECSU_EMERG_COUNT_EN
    exp_ec = m_ec;
`else
    exp_ec = 0;
`endif
    checks++;
    assert (st === 2'(m_st)) else begin
      errors++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, st, m_st);
    end
    checks++;
    assert (sev === (m_st >= 2)) else begin
      errors++;
      $error("FAIL %s severe obs=%0b exp=%0b", tag, sev, m_st >= 2);
    end
    checks++;
    assert (alrt === (m_st == 3)) else begin
      errors++;
      $error("FAIL %s alert obs=%0b exp=%0b", tag, alrt, m_st == 3);
    end
    checks++;
    assert (chg === 1'(m_chg)) else begin
      errors++;
      $error("FAIL %s changed obs=%0b exp=%0d", tag, chg, m_chg);
    end
    checks++;
    assert (ecnt === 8'(exp_ec)) else begin
      errors++;
      $error("FAIL %s count obs=%0d exp=%0d", tag, ecnt, exp_ec);
    end
  endtask

  task automatic expect_st(input string tag, input logic [1:0] e);
    checks++;
    assert (st === e) else begin
      errors++;
      $error("FAIL %s direct obs=%0d exp=%0d", tag, st, e);
    end
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    chk(tag);
  endtask

  task automatic set_in(input int w, input int v,
                        input int t, input bit s,
                        input bit a);
    wind = 6'(w);
    vis  = 2'(v);
    temp = 8'(t);
    ts   = s;
    ack  = a;
  endtask

  task automatic areset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk(tag);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int hold;
    model_reset();
    set_in(5, 0, 20, 0, 0);
    @(posedge CLK);
    #1;
    chk("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_reset");

    for (int i = 0; i < 10; i++) cyc("calm");
    expect_st("calm_end", 2'b00);

    set_in(25, 0, 20, 0, 0);
    cyc("esc_emerg");
    expect_st("esc_emerg", 2'b11);
    set_in(5, 0, 20, 0, 0);
    for (int i = 0; i < 20; i++) cyc("latched");
    expect_st("latched", 2'b11);

    set_in(5, 0, 20, 0, 1);
    cyc("ack");
    expect_st("ack", 2'b10);
    set_in(5, 0, 20, 0, 0);
    for (int i = 0; i < 3; i++) cyc("dw_hi");
    expect_st("dw_hi_hold", 2'b10);
    cyc("dw_hi_step");
    expect_st("dw_hi_step", 2'b01);
    for (int i = 0; i < 3; i++) cyc("dw_cau");
    expect_st("dw_cau_hold", 2'b01);
    cyc("dw_cau_step");
    expect_st("dw_cau_step", 2'b00);

    set_in(5, 0, 20, 1, 0);
    cyc("ts_on");
    set_in(5, 0, 20, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ts_off");
    set_in(5, 0, 20, 1, 0);
    cyc("ts_requal");
    set_in(5, 0, 20, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ts_off2");
    expect_st("ts_restart", 2'b10);
    cyc("ts_step");
    expect_st("ts_step", 2'b01);

    areset("rst_b1");
    set_in(20, 0, 20, 0, 0);
    cyc("wind20");
    expect_st("wind20", 2'b10);
    set_in(21, 0, 20, 0, 0);
    cyc("wind21");
    expect_st("wind21", 2'b11);
    set_in(25, 0, 20, 0, 1);
    cyc("ack_in_l3");
    expect_st("ack_in_l3", 2'b11);

    areset("rst_b2");
    set_in(0, 0, -40, 0, 0);
    cyc("tm40");
    expect_st("tm40", 2'b10);
    set_in(0, 0, -41, 0, 0);
    cyc("tm41");
    expect_st("tm41", 2'b11);

    areset("rst_b3");
    set_in(0, 2, 20, 0, 0);
    cyc("vis10");
    expect_st("vis10", 2'b01);

    set_in(30, 0, 20, 0, 0);
    cyc("pre_arst");
    areset("arst_emerg");
    expect_st("arst_emerg", 2'b00);
    cyc("after_arst");

    for (int n = 0; n < 300; n++) begin
      set_in($urandom_range(0, 25),
             $urandom_range(0, 3),
             int'($urandom_range(0, 100)) - 50,
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) begin
        wind = 6'($urandom_range(0, 10));
        vis = 2'd0;
        temp = 8'($urandom_range(0, 30));
      end
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) begin
        cyc("rand");
        ack = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) areset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
